// File: rtl/demux_pkg.sv
`default_nettype none
// demux_pkg: FSM state encoding and select-to-one-hot helper for stream_demux_decoder.
// Rev 1.0
package demux_pkg;

  // Widest channel count the decode helper supports.
  localparam int MAX_OUT = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic [MAX_OUT-1:0] onehot_dec(input int unsigned sel, input int unsigned n);
    onehot_dec = '0;
    if (sel < n) onehot_dec = {{(MAX_OUT-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_decoder_sat_counter.sv
`default_nettype none
// sat_counter: W-bit up-counter that sticks at all-ones; clr and rst force zero.
// Rev 1.0
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux_decoder.sv
`default_nettype none
// stream_demux_decoder: registered 1-to-N_OUT demux with valid/ready flow control and
// out-of-range drop; per-channel saturating transfer counters when DEMUX_STATS_EN is defined. Rev 1.0
module stream_demux_decoder
  import demux_pkg::*;
#(
  parameter  int N_OUT  = 4,
  parameter  int DATA_W = 1,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [N_OUT-1:0]   out_onehot,
`ifdef DEMUX_STATS_EN
  input  logic               cnt_clear,
  output logic [N_OUT*CNT_W-1:0] cnt_flat,
`endif
  output logic               drop_pulse
);

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   data_q;
  logic [N_OUT-1:0]    onehot_q;
  logic                drop_q;

  logic [MAX_OUT-1:0]  dec_full;
  logic [N_OUT-1:0]    dec;
  logic                sel_ok;
  logic                drain;
  logic                accept;
  logic                load;
  logic                unused_dec;

  assign dec_full   = onehot_dec(32'(in_sel), N_OUT);
  assign dec        = dec_full[N_OUT-1:0];
  assign unused_dec = ^dec_full;
  assign sel_ok     = |dec;

  // onehot_q is zero whenever EMPTY, so masking with it selects the held channel's ready.
  assign drain    = (state == ST_FULL) && |(onehot_q & out_ready);
  assign in_ready = (state == ST_EMPTY) || drain;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (accept && sel_ok) begin
      state_nxt = ST_FULL;
      load      = 1'b1;
    end else if (drain) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      data_q   <= '0;
      onehot_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      drop_q <= accept && !sel_ok;
      if (load) begin
        data_q   <= in_data;
        onehot_q <= dec;
      end else if (drain) begin
        onehot_q <= '0;
      end
    end
  end

  assign out_valid  = onehot_q;
  assign out_onehot = onehot_q;
  assign out_data   = data_q;
  assign drop_pulse = drop_q;

`ifdef DEMUX_STATS_EN
  for (genvar i = 0; i < N_OUT; i++) begin : g_stats
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clear),
      .inc (onehot_q[i] && out_ready[i]),
      .cnt (cnt_flat[i*CNT_W +: CNT_W])
    );
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_decoder.sv
`default_nettype none
// tb_stream_demux_decoder: randomized scoreboard bench for stream_demux_decoder,
// one 4-channel and one 3-channel instance; counter checks when DEMUX_STATS_EN is defined.
module tb_stream_demux_decoder;

  localparam int DW = 8;
  localparam int CW = 2;

  typedef struct {
    int           sel;
    logic [DW-1:0] data;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit done [2];

  function automatic void check(input string nm, input int n, input longint unsigned act,
                                input longint unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s [N_OUT=%0d]: got %0h expected %0h", nm, n, act, exp);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int N  = (k == 0) ? 4 : 3;
    localparam int SW = $clog2(N);
    localparam int CMAX = (1 << CW) - 1;

    logic          rst;
    logic          in_valid, in_ready, drop_pulse;
    logic [DW-1:0] in_data, out_data;
    logic [SW-1:0] in_sel;
    logic [N-1:0]  out_valid, out_ready, out_onehot;
`ifdef DEMUX_STATS_EN
    logic            cnt_clear;
    logic [N*CW-1:0] cnt_flat;
    int              mcnt [N];
`endif

    stream_demux_decoder #(
      .N_OUT (N),
`ifdef DEMUX_STATS_EN
      .CNT_W (CW),
`endif
      .DATA_W(DW)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_onehot(out_onehot),
`ifdef DEMUX_STATS_EN
      .cnt_clear (cnt_clear),
      .cnt_flat  (cnt_flat),
`endif
      .drop_pulse(drop_pulse)
    );

    // Reference model: the queue holds words accepted but not yet delivered (at most one).
    item_t         q [$];
    bit            exp_drop;
    bit            rst_seen;
    bit            acc_seen;
    bit            pend;
    logic [SW-1:0] pend_sel;
    logic [DW-1:0] pend_data;
    logic [N-1:0]  ev;
    bit            del, acc;

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        exp_drop = 1'b0;
        rst_seen = 1'b1;
        acc_seen = 1'b0;
        pend     = 1'b0;
`ifdef DEMUX_STATS_EN
        foreach (mcnt[i]) mcnt[i] = 0;
`endif
      end else begin
        ev = (q.size() > 0) ? (N'(1) << q[0].sel) : '0;
        check("out_valid", N, out_valid, ev);
        check("out_onehot", N, out_onehot, ev);
        check("in_ready", N, in_ready, (q.size() == 0) || ((ev & out_ready) != '0));
        check("drop_pulse", N, drop_pulse, exp_drop);
        if (q.size() > 0) check("out_data", N, out_data, q[0].data);
        else if (rst_seen) check("out_data_after_reset", N, out_data, 0);
        rst_seen = 1'b0;

        if (pend)
          assert (in_valid && in_sel == pend_sel && in_data == pend_data)
            else $error("producer changed a stalled input word");

        del = ((ev & out_ready) != '0);
        acc = in_valid && ((q.size() == 0) || del);
`ifdef DEMUX_STATS_EN
        for (int i = 0; i < N; i++) begin
          check("cnt", N, cnt_flat[i*CW +: CW], mcnt[i]);
          if (cnt_clear) mcnt[i] = 0;
          else if (ev[i] && out_ready[i] && mcnt[i] < CMAX) mcnt[i]++;
        end
`endif
        if (del) void'(q.pop_front());
        exp_drop = acc && (int'(in_sel) >= N);
        if (acc && int'(in_sel) < N) q.push_back('{sel: int'(in_sel), data: in_data});
        acc_seen  = acc;
        pend      = in_valid && !acc;
        pend_sel  = in_sel;
        pend_data = in_data;
      end
    end

    // Called at posedge+1; returns at posedge+1 after the word was taken.
    task automatic send(input int s, input int d);
      in_valid = 1'b1;
      in_sel   = SW'(s);
      in_data  = DW'(d);
      for (int t = 0; ; t++) begin
        @(posedge clk); #1;
        if (acc_seen) break;
        if (t > 1000) begin
          check("send_timeout", N, 0, 1);
          break;
        end
      end
      in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
`ifdef DEMUX_STATS_EN
      cnt_clear = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Sweep every encodable select back to back (includes an out-of-range one when N=3).
      out_ready = '1;
      for (int s = 0; s < (1 << SW); s++) send(s, $urandom);
      idle(3);

      // Backpressure on channel 2 while another word waits.
      out_ready = ~(N'(1) << 2);
      send(2, 8'h5a);
      in_valid = 1'b1; in_sel = SW'(1); in_data = 8'hc3;
      repeat (3) begin @(posedge clk); #1; end
      out_ready = '1;
      send(1, 8'hc3);
      idle(3);

      // Reset while holding an undelivered word.
      out_ready = '0;
      send(1, 8'hff);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = '1;
      idle(3);

`ifdef DEMUX_STATS_EN
      // Saturation on ch0, then a clear coinciding with a transfer.
      cnt_clear = 1'b1; idle(1); cnt_clear = 1'b0;
      for (int i = 0; i < 5; i++) send(0, i);
      idle(2);
      send(0, 8'h11);
      cnt_clear = 1'b1; idle(1); cnt_clear = 1'b0;
      idle(2);
`endif

      // Random traffic; a stalled word is held unchanged.
      for (int c = 0; c < 4000; c++) begin
        if (!(in_valid && !acc_seen)) begin
          in_valid = ($urandom % 3) != 0;
          in_sel   = SW'($urandom);
          in_data  = DW'($urandom);
        end
        out_ready = N'($urandom);
`ifdef DEMUX_STATS_EN
        cnt_clear = ($urandom % 50) == 0;
`endif
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = '1;
`ifdef DEMUX_STATS_EN
      cnt_clear = 1'b0;
`endif
      idle(5);
      check("drained", N, q.size(), 0);
      done[k] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000; t++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) check("global_timeout", 0, 0, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
